// File: rtl/sort_sequencer.sv
// Sequences a sort_top instance through one job: clear, load N elements, wait
// for the sorted result, drain N elements over a valid/ready stream.
module sort_sequencer #(
    parameter int LOG_INPUT_NUM = 7,
    parameter int DATA_WIDTH    = 32,
    parameter int RST_CYCLES    = 2,
    parameter int TIMEOUT       = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [LOG_INPUT_NUM:0]  elem_cnt,
    output logic                    srt_rst,
    output logic [DATA_WIDTH-1:0]   srt_din,
    output logic                    srt_now1,
    output logic                    srt_now2,
    input  logic                    srt_y_valid,
    input  logic [DATA_WIDTH-1:0]   srt_dout
);

    localparam int N  = 2 ** LOG_INPUT_NUM;
    localparam int CW = LOG_INPUT_NUM + 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] N_LAST   = CW'(N - 1);
    localparam logic [CW-1:0] N_CNT    = CW'(N);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_WAIT,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                 state, state_nxt;
    logic [RW-1:0]          rst_cnt, rst_cnt_nxt;
    logic [TW-1:0]          wait_cnt, wait_cnt_nxt;
    logic                   settle, settle_nxt;
    logic                   done_nxt, err_nxt;
    logic                   out_valid_nxt, now1_nxt, now2_nxt;
    logic [DATA_WIDTH-1:0]  out_data_nxt, din_nxt;
    logic [CW-1:0]          elem_cnt_nxt;
    logic                   capture, out_fire;

    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        wait_cnt_nxt  = wait_cnt;
        settle_nxt    = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = err;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        din_nxt       = srt_din;
        now1_nxt      = 1'b0;
        now2_nxt      = 1'b0;
        elem_cnt_nxt  = elem_cnt;
        out_fire      = out_valid && out_ready;
        capture       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt    = S_CLEAR;
                    err_nxt      = 1'b0;
                    elem_cnt_nxt = '0;
                    rst_cnt_nxt  = '0;
                end
            end
            S_CLEAR: begin
                if (rst_cnt == RST_LAST) state_nxt = S_LOAD;
                else                     rst_cnt_nxt = rst_cnt + 1'b1;
            end
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    din_nxt      = in_data;
                    now1_nxt     = 1'b1;
                    elem_cnt_nxt = elem_cnt + 1'b1;
                    if (elem_cnt == N_LAST) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = '0;
                    end
                end
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (srt_y_valid) begin
                    state_nxt    = S_DRAIN;
                    elem_cnt_nxt = '0;
                end else if (wait_cnt == TO_LAST) begin
                    state_nxt   = S_ERROR;
                    err_nxt     = 1'b1;
                    rst_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                // settle blocks capture for the cycle the sorter needs after srt_now2
                capture = !settle && (!out_valid || out_ready) && srt_y_valid &&
                          (elem_cnt != N_CNT);
                if (capture) begin
                    out_data_nxt  = srt_dout;
                    out_valid_nxt = 1'b1;
                    now2_nxt      = 1'b1;
                    elem_cnt_nxt  = elem_cnt + 1'b1;
                    settle_nxt    = 1'b1;
                end else if (out_fire) begin
                    out_valid_nxt = 1'b0;
                    if (elem_cnt == N_CNT) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                if (rst_cnt == RST_LAST) state_nxt = S_IDLE;
                else                     rst_cnt_nxt = rst_cnt + 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rst_cnt   <= '0;
            wait_cnt  <= '0;
            settle    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            elem_cnt  <= '0;
            srt_rst   <= 1'b0;
            srt_din   <= '0;
            srt_now1  <= 1'b0;
            srt_now2  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rst_cnt   <= rst_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            settle    <= settle_nxt;
            busy      <= (state_nxt != S_IDLE);
            done      <= done_nxt;
            err       <= err_nxt;
            in_ready  <= (state_nxt == S_LOAD);
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            elem_cnt  <= elem_cnt_nxt;
            srt_rst   <= (state_nxt == S_CLEAR) || (state_nxt == S_ERROR);
            srt_din   <= din_nxt;
            srt_now1  <= now1_nxt;
            srt_now2  <= now2_nxt;
        end
    end

endmodule

// File: tb/tb_sort_sequencer.sv
// Scoreboard bench for sort_sequencer with a behavioural ascending-sorter model
// standing in for sort_top.
module tb_sort_sequencer;

    localparam int LOG = 2;
    localparam int N   = 2 ** LOG;
    localparam int DW  = 8;
    localparam int RC  = 2;
    localparam int TO  = 16;

    logic          clk, rst, start;
    logic          busy, done, err;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [LOG:0]  elem_cnt;
    logic          srt_rst, srt_now1, srt_now2, srt_y_valid;
    logic [DW-1:0] srt_din, srt_dout;

    sort_sequencer #(
        .LOG_INPUT_NUM(LOG),
        .DATA_WIDTH   (DW),
        .RST_CYCLES   (RC),
        .TIMEOUT      (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .elem_cnt   (elem_cnt),
        .srt_rst    (srt_rst),
        .srt_din    (srt_din),
        .srt_now1   (srt_now1),
        .srt_now2   (srt_now2),
        .srt_y_valid(srt_y_valid),
        .srt_dout   (srt_dout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sorter model: collects loads, presents ascending order, advances on srt_now2.
    logic [DW-1:0] loaded[$];
    logic [DW-1:0] sorted[$];
    int            idx = 0, ydly = 0, y_delay = 0;
    bit            have = 0, sorter_dead = 0, y_gap = 0;
    logic          y_r = 0;
    logic [DW-1:0] dout_r = '0;

    always @(posedge clk) begin
        if (rst || srt_rst) begin
            loaded.delete();
            have = 0; idx = 0; ydly = 0;
            y_r    <= 1'b0;
            dout_r <= '0;
        end else begin
            if (srt_now1) begin
                loaded.push_back(srt_din);
                if (loaded.size() == N && !sorter_dead) begin
                    sorted = loaded;
                    sorted.sort();
                    idx = 0; have = 1; ydly = y_delay;
                end
            end else if (have && ydly > 0) begin
                ydly--;
            end
            if (srt_now2 && have && ydly == 0) idx++;
            y_r    <= have && ydly == 0 && idx < N;
            dout_r <= (have && idx < N) ? sorted[idx] : '0;
        end
    end
    assign srt_y_valid = y_r && !y_gap;
    assign srt_dout    = dout_r;

    // Consumer / sorter-stall driver.
    int or_mode = 0;
    bit gap_en  = 0;
    bit pat[4]  = '{1, 0, 0, 1};
    int ph      = 0;

    initial begin
        out_ready = 0;
        forever begin
            tick();
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = pat[ph]; ph = (ph + 1) % 4; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            y_gap = gap_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // Scoreboards and monitor.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] load_q[$];
    int now1_cnt, now2_cnt, out_cnt, done_cnt, rst_pulses, rst_run = 0;
    int cyc = 0, last_now2 = -1;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_unexpected: got %0d expected none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        if (srt_now1) begin
            now1_cnt++;
            if (load_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL load_unexpected: got %0d expected none", srt_din);
            end else begin
                chk("srt_din", srt_din, load_q.pop_front());
            end
        end
        if (srt_now2) begin
            if (or_mode == 0 && !gap_en && last_now2 >= 0) chk("drain_rate", cyc - last_now2, 2);
            last_now2 = cyc;
            now2_cnt++;
        end
        if (done) done_cnt++;
        if (srt_rst) rst_run++;
        else if (rst_run > 0) begin
            chk("srt_rst_len", rst_run, RC);
            rst_pulses++;
            rst_run = 0;
        end
    end

    // Job stimulus.
    logic [DW-1:0] stim_v[$];
    bit            stim_e[$];

    task automatic add(input logic [DW-1:0] v, input bit e);
        stim_v.push_back(v);
        stim_e.push_back(e);
    endtask

    task automatic make_random(input int maxv);
        int k;
        bit e;
        stim_v.delete(); stim_e.delete();
        k = 0;
        while (k < N) begin
            e = ($urandom_range(0, 2) != 0);
            add(DW'($urandom_range(0, maxv)), e);
            if (e) k++;
        end
        repeat ($urandom_range(0, 2)) add(DW'($urandom_range(0, maxv)), 1'($urandom_range(0, 1)));
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_err", err, 0);         chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0); chk("rst_srt_rst", srt_rst, 0);
        chk("rst_now1", srt_now1, 0);   chk("rst_now2", srt_now2, 0);
        chk("rst_out_data", out_data, 0); chk("rst_srt_din", srt_din, 0);
        chk("rst_elem_cnt", elem_cnt, 0);
    endtask

    task automatic start_job();
        int lat;
        start = 1;
        tick();
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("srt_rst_after_start", srt_rst, 1);
        chk("err_cleared_by_start", err, 0);
        lat = 1;
        while (!in_ready && lat < 50) begin tick(); lat++; end
        chk("in_ready_latency", lat, RC + 1);
    endtask

    task automatic run_job();
        int acc;
        logic [DW-1:0] first[$];
        logic [DW-1:0] srt[$];
        first.delete();
        foreach (stim_v[i]) if (stim_e[i] && first.size() < N) first.push_back(stim_v[i]);
        foreach (first[i]) load_q.push_back(first[i]);
        srt = first;
        srt.sort();
        if (!sorter_dead) foreach (srt[i]) exp_q.push_back(srt[i]);
        now1_cnt = 0; now2_cnt = 0; out_cnt = 0; done_cnt = 0; rst_pulses = 0; last_now2 = -1;
        start_job();
        acc = 0;
        foreach (stim_v[i]) begin
            in_valid = stim_e[i];
            in_data  = stim_v[i];
            tick();
            if (stim_e[i]) begin
                acc++;
                if (acc == N) chk("in_ready_after_last", in_ready, 0);
            end
        end
        in_valid = 0;
        chk("srt_din_last", srt_din, first[N-1]);
    endtask

    task automatic finish_job();
        int n;
        n = 0;
        while (!done && n < 500) begin tick(); n++; end
        chk("done_seen", done, 1);
        chk("busy_with_done", busy, 1);
        chk("elem_cnt_done", elem_cnt, N);
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("now1_count", now1_cnt, N);
        chk("now2_count", now2_cnt, N);
        chk("out_count", out_cnt, N);
        chk("done_count", done_cnt, 1);
        chk("err_low", err, 0);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("clear_pulses", rst_pulses, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1; start = 0; in_valid = 0; in_data = '0;
        repeat (3) tick();
        check_reset_vals();
        rst = 0;
        tick();

        // Basic job, full throughput.
        or_mode = 0;
        stim_v.delete(); stim_e.delete();
        add(9, 1); add(3, 1); add(7, 1); add(1, 1);
        run_job(); finish_job();

        // Backpressure 1,0,0,1.
        or_mode = 1;
        run_job(); finish_job();

        // Input gaps and overrun: the 5th valid value (50) must never load.
        or_mode = 0;
        stim_v.delete(); stim_e.delete();
        add(10, 1); add(99, 0); add(20, 1); add(98, 0); add(30, 1); add(40, 1); add(50, 1);
        run_job(); finish_job();

        // Timeout: sorter never answers.
        sorter_dead = 1;
        stim_v.delete(); stim_e.delete();
        add(5, 1); add(6, 1); add(7, 1); add(8, 1);
        run_job();
        n = 0;
        while (!err && n < 100) begin tick(); n++; end
        chk("timeout_cycles", n, TO);
        chk("busy_in_error", busy, 1);
        chk("srt_rst_in_error", srt_rst, 1);
        repeat (RC) tick();
        chk("busy_after_error", busy, 0);
        chk("err_sticky", err, 1);
        chk("srt_rst_after_error", srt_rst, 0);
        tick();
        chk("error_rst_pulses", rst_pulses, 2);
        sorter_dead = 0;

        // Next job clears err (checked in start_job).
        make_random(255);
        run_job(); finish_job();

        // Reset after the second load.
        load_q.push_back(8'd11); load_q.push_back(8'd22);
        start_job();
        in_valid = 1; in_data = 11; tick();
        in_data = 22; tick();
        in_valid = 0; rst = 1; tick();
        check_reset_vals();
        rst = 0;
        chk("load_q_after_rst", load_q.size(), 0);
        tick();
        stim_v.delete(); stim_e.delete();
        add(4, 1); add(4, 1); add(0, 1); add(2, 1);
        run_job(); finish_job();

        // start during WAIT is ignored.
        y_delay = 6;
        stim_v.delete(); stim_e.delete();
        add(200, 1); add(100, 1); add(150, 1); add(50, 1);
        run_job();
        tick();
        start = 1; tick(); start = 0;
        chk("busy_during_wait", busy, 1);
        chk("no_clear_on_busy_start", srt_rst, 0);
        finish_job();
        y_delay = 0;

        // Randomized jobs with backpressure and sorter stalls.
        or_mode = 2; gap_en = 1;
        for (int j = 0; j < 8; j++) begin
            make_random((j % 2 == 0) ? 15 : 255);
            y_delay = $urandom_range(0, 3);
            run_job(); finish_job();
        end
        gap_en = 0; or_mode = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sort_sequencer.md
# sort_sequencer

Controller that sequences one `sort_top` instance through a complete sort job: clear, load N elements, wait for the result, drain N sorted elements. It sits between the memory-mapped peripheral and the sorter. It replaces firmware bit-banging of `rst`/`din`/`now1`/`now2` with valid/ready streams and a start/done/error handshake. N = 2**LOG_INPUT_NUM.

## Interface
Parameters:
- `LOG_INPUT_NUM`, 7, log2 of elements per job (N).
- `DATA_WIDTH`, 32, element width.
- `RST_CYCLES`, 2, cycles `srt_rst` is held high in CLEAR (≥1).
- `TIMEOUT`, 4096, maximum WAIT cycles before error (≥1).

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a job completes.
- `err`  out  1  sticky timeout flag; cleared by `start` or `rst`.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  high only in LOAD.
- `in_data`  in  DATA_WIDTH  unsorted element.
- `out_valid`  out  1  sorted element valid.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  DATA_WIDTH  sorted element.
- `elem_cnt`  out  LOG_INPUT_NUM+1  elements loaded (LOAD) or emitted (DRAIN).
- `srt_rst`  out  1  to `sort_top.rst`.
- `srt_din`  out  DATA_WIDTH  to `sort_top.din`.
- `srt_now1`  out  1  load strobe to `sort_top.now1`.
- `srt_now2`  out  1  advance strobe to `sort_top.now2`.
- `srt_y_valid`  in  1  from `sort_top.y_valid`.
- `srt_dout`  in  DATA_WIDTH  from `sort_top.dout`.

## Operation
- Sorter contract:
  - `srt_din` is taken on a cycle with `srt_now1`=1.
  - After N loads, `srt_y_valid` rises and `srt_dout` presents the head element.
  - A one-cycle `srt_now2` advances to the next element, which is valid one cycle later.
- States: IDLE, CLEAR, LOAD, WAIT, DRAIN, DONE, ERROR.
- IDLE:
  - `start` loads CLEAR, clears `err` and zeroes `elem_cnt`.
  - `start` in any other state is ignored.
- CLEAR:
  - `srt_rst`=1 for exactly RST_CYCLES cycles, then LOAD.
- LOAD:
  - `in_ready`=1.
  - Each `in_valid && in_ready` registers `in_data` into `srt_din`, pulses `srt_now1` for one cycle and increments `elem_cnt`.
  - The Nth handshake moves to WAIT with `in_ready` low the next cycle. No N+1th element is accepted.
- WAIT:
  - The timeout counter starts from 0.
  - `srt_y_valid`=1 moves to DRAIN with `elem_cnt` zeroed.
  - The counter reaching TIMEOUT moves to ERROR.
- DRAIN: two-phase loop per element.
  - Capture phase, taken when the output register is empty (or accepted this cycle) and `srt_y_valid`=1: `out_data`<=`srt_dout`, `out_valid`<=1, pulse `srt_now2`, `elem_cnt`++.
  - Settle phase: one cycle with no capture.
  - After the Nth capture, wait for its `out_ready` handshake, then go to DONE.
  - `out_valid`/`out_data` are held stable while `out_ready`=0 (no drop, no duplicate).
- DONE: `done`=1 for one cycle, then IDLE.
- ERROR:
  - `err`=1.
  - `srt_rst` is pulsed for RST_CYCLES cycles, then IDLE. `err` stays set.
- `rst` in any state: IDLE next edge; in-flight data is discarded.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `err`, `in_ready`, `out_valid`, `srt_rst`, `srt_now1`, `srt_now2` = 0.
  - `out_data`, `srt_din`, `elem_cnt` = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- `start` at edge t: `busy`=1 and `srt_rst`=1 from t+1 to t+RST_CYCLES; `in_ready`=1 from t+RST_CYCLES+1.
- Load throughput: one element per cycle. `srt_now1` follows the handshake by one cycle, with `srt_din` valid in the same cycle.
- Drain throughput: one element per 2 cycles with `out_ready` held high.
- `done` is asserted the cycle after the final output handshake; `busy` falls one cycle after `done`.
- Simultaneous events:
  - `srt_y_valid` on the same cycle the timeout counter reaches TIMEOUT: `srt_y_valid` wins, go to DRAIN.
  - `srt_y_valid` dropping during DRAIN stalls capture without error.

## Test plan
- LOG_INPUT_NUM=2: `start`, stream 9,3,7,1 with `in_valid` always high and `out_ready`=1. Expect `out_data` 1,3,7,9 (ASCENDING sorter), exactly 4 `srt_now1` and 4 `srt_now2` pulses, `done` once, `err`=0.
- Backpressure: same job with `out_ready` toggling 1,0,0,1. Expect each `out_data` held while `out_ready`=0, no duplicates, 4 outputs total.
- Input gaps and overrun: `in_valid` 1,0,1,0,1,1,1. Expect exactly 4 accepted, `in_ready`=0 after the 4th, and the 5th value never reaching `srt_din`.
- Timeout: TIMEOUT=16 with the sorter model never raising `srt_y_valid`. Expect ERROR after 16 WAIT cycles, `err`=1, `srt_rst` pulsed RST_CYCLES cycles, return to IDLE. A following `start` clears `err`.
- Reset mid-job: assert `rst` for 1 cycle after the 2nd load. Expect all outputs at reset values next cycle. A new job of 4,4,0,2 then yields 0,2,4,4.
- `start` while busy (during WAIT): ignored. Expect no extra CLEAR and no `srt_rst` pulse.
